// File: rtl/counter_cmd_debouncer.sv
// Debounces the up/down pushbuttons and turns accepted presses into the counter's
// en/up pulses, plus a syn_clr pulse when both buttons are held together.

module counter_cmd_debouncer_chan #(
    parameter int DB_CYCLES = 2000000,
    parameter int TW        = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic lvl,
    output logic rise
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

    localparam logic [TW-1:0] LAST = TW'(DB_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          rise_q, rise_d;
    logic          lvl_q, lvl_d;

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        state_d = state_q;
        timer_d = timer_q;
        rise_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s2_q) begin
                    state_d = WAIT1;
                    timer_d = '0;
                end
            end
            WAIT1: begin
                if (!s2_q) begin
                    state_d = ZERO;
                end else if (timer_q == LAST) begin
                    state_d = ONE;
                    rise_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ONE: begin
                if (!s2_q) begin
                    state_d = WAIT0;
                    timer_d = '0;
                end
            end
            WAIT0: begin
                if (s2_q) begin
                    state_d = ONE;
                end else if (timer_q == LAST) begin
                    state_d = ZERO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ZERO;
        endcase
        lvl_d = (state_d == ONE) || (state_d == WAIT0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ZERO;
            timer_q <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            rise_q  <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            rise_q  <= rise_d;
            lvl_q   <= lvl_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = rise_q;
endmodule

module counter_cmd_debouncer #(
    parameter int DB_CYCLES = 2000000,
    parameter int TW        = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_dn,
    output logic en,
    output logic up,
    output logic syn_clr,
    output logic up_lvl,
    output logic dn_lvl
);
    logic up_rise, dn_rise;
    logic en_q, en_d;
    logic up_q, up_d;
    logic syn_clr_q, syn_clr_d;
    logic both_q, both_d;

    counter_cmd_debouncer_chan #(.DB_CYCLES(DB_CYCLES), .TW(TW)) u_up_chan (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_up),
        .lvl   (up_lvl),
        .rise  (up_rise)
    );

    counter_cmd_debouncer_chan #(.DB_CYCLES(DB_CYCLES), .TW(TW)) u_dn_chan (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_dn),
        .lvl   (dn_lvl),
        .rise  (dn_rise)
    );

    // A clear wins over a count; simultaneous ticks cancel and leave direction alone.
    always_comb begin
        both_d    = up_lvl & dn_lvl;
        syn_clr_d = both_d & ~both_q;
        en_d      = (up_rise ^ dn_rise) & ~syn_clr_d;
        up_d      = up_q;
        if (en_d) begin
            up_d = up_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            up_q      <= 1'b1;
            syn_clr_q <= 1'b0;
            both_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            up_q      <= up_d;
            syn_clr_q <= syn_clr_d;
            both_q    <= both_d;
        end
    end

    assign en      = en_q;
    assign up      = up_q;
    assign syn_clr = syn_clr_q;
endmodule
